// File: rtl/fft_bf_scheduler_pkg.sv
// Shared types and address arithmetic for the in-place radix-2 DIT FFT butterfly scheduler.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned MAX_LOG2N = 12;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addr0;
    logic [MAX_LOG2N-1:0] addr1;
    logic [MAX_LOG2N-2:0] tw;
  } bf_addr_t;

  function automatic int unsigned n_half(input int unsigned log2n);
    return 32'd1 << (log2n - 1);
  endfunction

  // Butterfly j of stage s pairs words k apart by span inside group g; the
  // twiddle stride shrinks by half each stage.
  function automatic bf_addr_t bf_addr(input int unsigned s, input int unsigned j,
                                       input int unsigned log2n);
    int unsigned span, g, k, a0;
    bf_addr_t r;
    span    = 32'd1 << s;
    g       = j >> s;
    k       = j & (span - 1);
    a0      = (g << (s + 1)) | k;
    r.addr0 = 12'(a0);
    r.addr1 = 12'(a0 + span);
    r.tw    = 11'(k << (log2n - 1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_scheduler_if.sv
// Control and memory-strobe bundle between the scheduler and the FFT control/datapath.
interface fft_bf_scheduler_if #(
  parameter int LOG2N = 6
);
  localparam int SW = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr0;
  logic [LOG2N-1:0] rd_addr1;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr0;
  logic [LOG2N-1:0] wr_addr1;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr,
           wr_en, wr_addr0, wr_addr1
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr,
           wr_en, wr_addr0, wr_addr1
  );
endinterface

// File: rtl/fft_bf_scheduler_delay_line.sv
// Fixed-depth shift register carrying read strobes/addresses to the write-back port.
module fft_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // NOTE: every stage is cleared, not just the head, so no stale write strobe
  // can surface after a reset aborts a transform.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_bf_scheduler.sv
// Issues one butterfly per cycle over LOG2N stages, draining PIPE_LAT cycles between
// stages so every read of a stage follows the previous stage's last write-back.
module fft_bf_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2N    = 6,
  parameter int PIPE_LAT = 2
) (
  input logic                clock,
  input logic                reset,
  fft_bf_scheduler_if.master bus
);

  localparam int N_HALF = int'(n_half(LOG2N));
  localparam int SW     = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;
  localparam int JW     = LOG2N - 1;
  localparam int DW     = $clog2(PIPE_LAT + 1);

  state_t        state;
  logic [SW-1:0] s;
  logic [JW-1:0] j;
  logic [DW-1:0] dcnt;

  logic [SW-1:0] issue_s;
  logic [JW-1:0] issue_j;
  bf_addr_t      nxt;

  // Coordinates of the butterfly that will be presented next cycle.
  always_comb begin
    issue_s = s;
    issue_j = j + JW'(1);
    case (state)
      ST_IDLE: begin
        issue_s = '0;
        issue_j = '0;
      end
      ST_DRAIN: begin
        issue_s = s + SW'(1);
        issue_j = '0;
      end
      default: ;
    endcase
    nxt = bf_addr(32'(issue_s), 32'(issue_j), LOG2N);
  end

  // NOTE: all state and outputs use non-blocking assignments so every output
  // reflects one consistent pre-edge snapshot of the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      j            <= '0;
      dcnt         <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rd_en    <= 1'b0;
      bus.stage    <= '0;
      bus.rd_addr0 <= '0;
      bus.rd_addr1 <= '0;
      bus.tw_addr  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state        <= ST_ISSUE;
            s            <= '0;
            j            <= '0;
            bus.busy     <= 1'b1;
            bus.rd_en    <= 1'b1;
            bus.stage    <= issue_s;
            bus.rd_addr0 <= LOG2N'(nxt.addr0);
            bus.rd_addr1 <= LOG2N'(nxt.addr1);
            bus.tw_addr  <= (LOG2N-1)'(nxt.tw);
          end
        end
        ST_ISSUE: begin
          if (j == JW'(N_HALF - 1)) begin
            state     <= ST_DRAIN;
            dcnt      <= DW'(PIPE_LAT);
            bus.rd_en <= 1'b0;
          end else begin
            j            <= issue_j;
            bus.rd_addr0 <= LOG2N'(nxt.addr0);
            bus.rd_addr1 <= LOG2N'(nxt.addr1);
            bus.tw_addr  <= (LOG2N-1)'(nxt.tw);
          end
        end
        ST_DRAIN: begin
          if (dcnt == DW'(1)) begin
            if (s == SW'(LOG2N - 1)) begin
              state    <= ST_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state        <= ST_ISSUE;
              s            <= issue_s;
              j            <= '0;
              bus.rd_en    <= 1'b1;
              bus.stage    <= issue_s;
              bus.rd_addr0 <= LOG2N'(nxt.addr0);
              bus.rd_addr1 <= LOG2N'(nxt.addr1);
              bus.tw_addr  <= (LOG2N-1)'(nxt.tw);
            end
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [2*LOG2N:0] rd_bundle;
  logic [2*LOG2N:0] wr_bundle;

  assign rd_bundle = {bus.rd_en, bus.rd_addr0, bus.rd_addr1};
  assign {bus.wr_en, bus.wr_addr0, bus.wr_addr1} = wr_bundle;

  fft_delay_line #(
    .DEPTH(PIPE_LAT),
    .WIDTH(2 * LOG2N + 1)
  ) u_wb_delay (
    .clock(clock),
    .clear(reset),
    .d    (rd_bundle),
    .q    (wr_bundle)
  );

endmodule
